// File: rtl/pat_det_pkg.sv
// Shared constants, derived widths and state encoding for the serial
// pattern detector scan controller.
package pat_det_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PAT_W  = 4;
  localparam int unsigned DIV_W  = 20;

  localparam int unsigned IDX_W  = $clog2(DATA_W);
  localparam int unsigned CNT_W  = $clog2(DATA_W - PAT_W + 2);
  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/pat_tick_gen.sv
// Loadable down-counter clock-enable generator.
// Ports:
//   clk, reset_n : system clock, synchronous active-low reset
//   load         : load counter with period (start of a scan)
//   en           : count while high
//   period       : bit period minus one, in clk cycles
//   tick         : one-cycle enable when the counter has reached zero
module pat_tick_gen
  import pat_det_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Reload on every tick so the next bit is period+1 cycles later.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = period;
    end else if (en) begin
      cnt_d = (cnt_q == '0) ? period : cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/pat_scan_ctrl.sv
// Scan controller: latches a word and pattern on start, shifts the word
// MSB-first into a PAT_W-bit window at a programmable bit rate and reports
// matches, match count, first match position and a done pulse.
// Ports:
//   clk, reset_n        : system clock, synchronous active-low reset
//   start               : scan request (honoured only while idle)
//   data, pattern, div  : word, pattern and bit period-1, latched on start
//   busy                : scan in progress
//   done                : one-cycle pulse after the last bit
//   match               : one-cycle pulse per matching window
//   match_cnt, found    : match statistics of the current/last scan
//   first_pos           : LSB index of the first matching window
module pat_scan_ctrl
  import pat_det_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic [PAT_W-1:0]  pattern,
  input  logic [DIV_W-1:0]  div,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic [5:0]        match_cnt,
  output logic              found,
  output logic [4:0]        first_pos
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PAT_W-1:0]    win_q, win_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    pos_q, pos_d;
  logic                found_q, found_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                match_q, match_d;

  logic                load_c;
  logic [DIV_W-1:0]    period_c;
  logic                tick_c;
  logic [PAT_W-1:0]    win_shift_c;
  logic [FILL_W-1:0]   fill_inc_c;
  logic                hit_c;

  // Period comes straight from the input on the load cycle, from the
  // latched copy on every reload.
  assign load_c   = (state_q == IDLE) && start;
  assign period_c = load_c ? div : div_q;

  pat_tick_gen u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load_c),
    .en      (state_q == SHIFT),
    .period  (period_c),
    .tick    (tick_c)
  );

  // Window after the pending shift; compare only once it is full.
  assign win_shift_c = {win_q[PAT_W-2:0], data_q[idx_q]};
  assign fill_inc_c  = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
  assign hit_c       = (fill_inc_c == FILL_W'(PAT_W)) && (win_shift_c == pat_q);

  // Next-state and output decode.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pat_d   = pat_q;
    div_d   = div_q;
    idx_d   = idx_q;
    win_d   = win_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    found_d = found_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    match_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = data;
          pat_d   = pattern;
          div_d   = div;
          idx_d   = IDX_W'(DATA_W - 1);
          win_d   = '0;
          fill_d  = '0;
          cnt_d   = '0;
          pos_d   = '0;
          found_d = 1'b0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick_c) begin
          win_d  = win_shift_c;
          fill_d = fill_inc_c;
          if (hit_c) begin
            match_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (!found_q) begin
              found_d = 1'b1;
              pos_d   = idx_q;
            end
          end
          if (idx_q == '0) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      pat_q   <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      win_q   <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      found_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      pat_q   <= pat_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      win_q   <= win_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      found_q <= found_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign match     = match_q;
  assign match_cnt = 6'(cnt_q);
  assign found     = found_q;
  assign first_pos = pos_q;

endmodule

// File: tb/tb_pat_scan_ctrl.sv
// Bench for pat_scan_ctrl: an elapsed-cycle arithmetic model checked every
// cycle, plus directed scans with hand-computed expectations.
module tb_pat_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] data;
  logic [3:0]  pattern;
  logic [19:0] div;
  logic        busy, done, match, found;
  logic [5:0]  match_cnt;
  logic [4:0]  first_pos;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  pat_scan_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .data      (data),
    .pattern   (pattern),
    .div       (div),
    .busy      (busy),
    .done      (done),
    .match     (match),
    .match_cnt (match_cnt),
    .found     (found),
    .first_pos (first_pos)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Model: bit n of a scan is shifted n*(div+1) cycles after the start edge;
  // the window ending at that bit is data[32-n+3 : 32-n].
  bit          m_busy = 0, m_done = 0, m_match = 0, m_found = 0;
  int          m_cnt = 0, m_pos = 0;
  longint      m_el = 0;
  logic [31:0] m_data = '0;
  logic [3:0]  m_pat = '0;
  longint      m_per = 1;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_busy = 0; m_done = 0; m_match = 0; m_found = 0;
      m_cnt = 0; m_pos = 0; m_el = 0;
    end else begin
      m_done  = 0;
      m_match = 0;
      if (!m_busy) begin
        if (start) begin
          m_data = data; m_pat = pattern; m_per = longint'(div) + 1;
          m_el = 0; m_busy = 1; m_cnt = 0; m_found = 0; m_pos = 0;
        end
      end else begin
        m_el++;
        if (m_el % m_per == 0) begin
          longint n;
          int     lsb;
          n = m_el / m_per;
          lsb = 32 - int'(n);
          if (n >= 4 && ((m_data >> lsb) & 32'hF) == {28'd0, m_pat}) begin
            m_match = 1;
            m_cnt++;
            if (!m_found) begin
              m_found = 1;
              m_pos = lsb;
            end
          end
          if (n == 32) begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("busy",      busy,      m_busy);
      chk("done",      done,      m_done);
      chk("match",     match,     m_match);
      chk("match_cnt", match_cnt, m_cnt);
      chk("found",     found,     m_found);
      chk("first_pos", first_pos, m_pos);
    end
  end

  int match_edges[$];

  // Called at posedge+1; edge 0 is the accepting edge.
  task automatic scan(input logic [31:0] d, input logic [3:0] p,
                      input logic [19:0] dv, input int disturb_at,
                      input int budget, output int done_edge);
    int e;
    start = 1'b1; data = d; pattern = p; div = dv;
    e = -1;
    done_edge = -1;
    match_edges.delete();
    while (done_edge < 0 && e < budget) begin
      @(posedge clk); #1;
      e++;
      if (e == 0) start = 1'b0;
      if (disturb_at > 0 && e == disturb_at) begin
        start = 1'b1; data = ~d; pattern = ~p; div = dv + 20'd3;
      end
      if (disturb_at > 0 && e == disturb_at + 1) start = 1'b0;
      if (match) match_edges.push_back(e);
      if (done) done_edge = e;
    end
    if (done_edge < 0) chk("scan_timeout", 0, 1);
  endtask

  localparam logic [31:0] D1 = 32'b01100110110111110001100011010110;

  initial begin
    int de;
    int exp1[6] = '{4, 8, 11, 22, 27, 32};
    int dones[$];
    int low_cnt;
    int e;

    reset_n = 1'b0; start = 1'b0; data = '0; pattern = '0; div = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_match", match, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_found", found, 0);
    chk("rst_pos", first_pos, 0);
    chk_en = 1'b1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: pattern 0110, one bit per clock.
    scan(D1, 4'b0110, 20'd0, 0, 200, de);
    chk("t1_done_edge", de, 32);
    chk("t1_cnt", match_cnt, 6);
    chk("t1_found", found, 1);
    chk("t1_pos", first_pos, 28);
    chk("t1_nmatch", match_edges.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < match_edges.size()) chk("t1_match_edge", match_edges[i], exp1[i]);

    // Test 2: pattern 1111, div=2.
    scan(D1, 4'b1111, 20'd2, 0, 400, de);
    chk("t2_done_edge", de, 96);
    chk("t2_cnt", match_cnt, 2);
    chk("t2_pos", first_pos, 17);

    // Test 3: all-zero word and pattern, then all ones against zero pattern.
    scan(32'h0, 4'h0, 20'd0, 0, 200, de);
    chk("t3_cnt", match_cnt, 29);
    chk("t3_nmatch", match_edges.size(), 29);
    if (match_edges.size() > 0) begin
      chk("t3_first_edge", match_edges[0], 4);
      chk("t3_last_with_done", match_edges[match_edges.size()-1], de);
    end
    scan(32'hFFFF_FFFF, 4'h0, 20'd0, 0, 200, de);
    chk("t3b_cnt", match_cnt, 0);
    chk("t3b_found", found, 0);
    chk("t3b_pos", first_pos, 0);

    // Test 4: start pulse and input changes mid-scan are ignored.
    scan(D1, 4'b0110, 20'd1, 10, 400, de);
    chk("t4_done_edge", de, 64);
    chk("t4_cnt", match_cnt, 6);
    chk("t4_pos", first_pos, 28);

    // Test 5: reset during the scan, then a fresh scan.
    start = 1'b1; data = D1; pattern = 4'b0110; div = '0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_pre_cnt", match_cnt, 2);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("t5_busy", busy, 0);
    chk("t5_cnt", match_cnt, 0);
    chk("t5_found", found, 0);
    chk("t5_pos", first_pos, 0);
    chk("t5_match", match, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_idle", busy, 0);
    scan(D1, 4'b0110, 20'd0, 0, 200, de);
    chk("t5_fresh_cnt", match_cnt, 6);
    start = 1'b1; reset_n = 1'b0;
    @(posedge clk); #1;
    chk("t5_rst_start_busy", busy, 0);
    start = 1'b0; reset_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_rst_start_idle", busy, 0);

    // Test 6: start held high restarts in each done cycle.
    start = 1'b1; data = D1; pattern = 4'b0110; div = '0;
    e = -1; low_cnt = 0;
    while (dones.size() < 3 && e < 200) begin
      @(posedge clk); #1;
      e++;
      if (dones.size() > 0 && !busy) low_cnt++;
      if (done) begin
        dones.push_back(e);
        if (dones.size() == 1) low_cnt = busy ? 0 : 1;
        if (dones.size() == 3) start = 1'b0;
        else chk("t6_cnt_at_done", match_cnt, 6);
      end
    end
    chk("t6_ndone", dones.size(), 3);
    if (dones.size() == 3) begin
      chk("t6_first_done", dones[0], 32);
      chk("t6_gap1", dones[1] - dones[0], 33);
      chk("t6_gap2", dones[2] - dones[1], 33);
      chk("t6_busy_low_cycles", low_cnt, 3);
      chk("t6_cnt", match_cnt, 6);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("t6_idle_after", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pat_scan_ctrl.md
# pat_scan_ctrl

Sequencing controller for the 4-bit serial pattern detector. It latches a 32-bit data word and a 4-bit pattern on a start request, then serialises the word MSB-first into a 4-bit sliding window at a programmable bit rate. It reports every match, the match count and the position of the first match, and signals completion with a one-cycle done pulse. The bit rate comes from a clock-enable tick counter instead of cascaded divided clocks, so the whole block runs on the single system clock.

## Interface
- DATA_W, 32, data word width; bits scanned from DATA_W-1 down to 0
- PAT_W, 4, pattern/window width
- DIV_W, 20, width of the bit-period divider value
- clk  input  1  system clock; all logic on rising edge
- reset_n  input  1  one clock; reset is synchronous and active-low
- start  input  1  scan request; sampled only in IDLE
- data  input  DATA_W  word to scan; latched on accepted start
- pattern  input  PAT_W  pattern to detect; latched on accepted start
- div  input  DIV_W  bit period minus one, in clk cycles; latched on accepted start
- busy  output  1  high while a scan is in progress
- done  output  1  one-cycle pulse after the last bit is processed
- match  output  1  one-cycle pulse per window equal to the pattern
- match_cnt  output  6  matches in the current/last scan (max DATA_W-PAT_W+1 = 29)
- found  output  1  at least one match in the current/last scan
- first_pos  output  5  LSB bit index in data of the first matching window; 0 if none

## Operation
- States: IDLE, SHIFT. Decode done as a registered pulse, not as a state.
- IDLE and start=1: latch data, pattern and div. Load the bit index with DATA_W-1. Clear the window, fill count, match_cnt, found and first_pos. Load the tick counter with div. Go to SHIFT and set busy=1.
- SHIFT: the tick counter decrements each cycle. At 0 it produces a tick and reloads div.
- On each tick: next window = {window[PAT_W-2:0], data_l[idx]}. Increment fill, saturating at PAT_W.
- Compare only when the shift brings fill to at least PAT_W. On equality, at the same edge: match<=1, match_cnt+=1, and if found=0 then found<=1 and first_pos<=idx.
- Overlapping matches count (pattern 0110 in 0110110 gives 2).
- A tick with idx=0 is the last bit. At that edge the block returns to IDLE with busy<=0 and done<=1. A match on the last bit is pulsed in the same cycle as done.
- Otherwise each tick decrements idx.
- start in SHIFT is ignored. Changes on data/pattern/div during SHIFT have no effect.
- match_cnt, found and first_pos hold until the next accepted start.
- reset_n=0 at any edge (including mid-scan, and simultaneous with start): IDLE. All outputs and internal registers go to 0. Reset wins over start.

## Timing
- Reset values: busy=0, done=0, match=0, match_cnt=0, found=0, first_pos=0.
- Start accepted at edge k: busy=1 from cycle k+1.
- Bit n (n=1 for data[31]) is shifted at edge k+n*(div+1).
- match is high in the cycle following the tick edge at which the matching window's LSB enters.
- done is high, and busy is low, in the cycle after edge k+DATA_W*(div+1). Total latency is DATA_W*(div+1) cycles.
- A new start is accepted in the done cycle. Back-to-back scans therefore have no dead cycle beyond done.
- div=0: one bit per clock. div = 2^DIV_W-1 is legal and is not special-cased.

## Structure
- Shared package pat_det_pkg holds:
  - the DATA_W and PAT_W constants
  - the state encoding (IDLE, SHIFT)
  - derived widths: IDX_W=$clog2(DATA_W), CNT_W=$clog2(DATA_W-PAT_W+2)
- One sub-module, pat_tick_gen: loadable down-counter clock-enable generator (inputs load, en, period; output tick). It replaces the ripple T-flip-flop dividers; no derived clocks.
- Implement the window and compare inline; no separate shift-register instance.

## Test plan
- data=32'b01100110110111110001100011010110, pattern=4'b0110, div=0, start at edge 0 -> match pulses after edges 4, 8, 11, 22, 27, 32; done after edge 32; match_cnt=6, found=1, first_pos=28.
- Same data, pattern=4'b1111, div=2 -> match_cnt=2, first_pos=17, done in the cycle after edge 96.
- data=0, pattern=0, div=0 -> 29 consecutive match pulses after edges 4 through 32, with the last coincident with done; match_cnt=29. Then data=32'hFFFFFFFF, pattern=0 -> match_cnt=0, found=0, first_pos=0.
- Pulse start again mid-scan and change data/pattern while busy -> no restart; results identical to an undisturbed scan.
- reset_n=0 for one edge at bit 10 of a scan -> all outputs 0, IDLE next cycle; a fresh start then completes normally. Assert start and reset_n=0 together -> stays IDLE, busy=0.
- start held high continuously -> a new scan begins in each done cycle; busy drops for exactly that one cycle; counters clear per scan.
